counter_updown_presc_tristate: RTL and testbench

//  Parametrised up/down loadable counter, successor to the 8-bit loadable counter.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_updown_presc_tristate_if.sv | 39 +++
 rtl/counter_prescaler.sv | 27 ++
 rtl/counter_updown_presc_tristate.sv | 94 +++++++++
 tb/tb_counter_updown_presc_tristate.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared types for the up/down prescaled counter: count modes and FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } cnt_mode_e;

    typedef enum logic {
        ST_RUN,
        ST_DONE
    } cnt_state_e;

endpackage

// File: rtl/counter_updown_presc_tristate_if.sv
// Control/status bundle of the counter; cmp_val/match exist only with COUNTER_CMP_EN.
interface counter_updown_presc_tristate_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    logic               en;
    logic               up;
    logic [1:0]         mode;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   max_val;
    logic [PRESC_W-1:0] presc;
    logic               oe;
    logic               tc;
    logic               done;
`ifdef COUNTER_CMP_EN
    logic [WIDTH-1:0]   cmp_val;
    logic               match;
`endif

    modport slave (
        input  en, up, mode, load, load_val, max_val, presc, oe,
`ifdef COUNTER_CMP_EN
        input  cmp_val,
        output match,
`endif
        output tc, done
    );

    modport master (
        output en, up, mode, load, load_val, max_val, presc, oe,
`ifdef COUNTER_CMP_EN
        output cmp_val,
        input  match,
`endif
        input  tc, done
    );

endinterface

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick on every (presc+1)-th enabled cycle; clr restarts the phase.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == presc);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pcnt <= '0;
        end else if (clr || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_updown_presc_tristate.sv
// Up/down loadable counter with wrap/saturate/one-shot modes, prescaled enable and tri-stated q.
// Optional compare output (cmp_val/match) enabled by defining COUNTER_CMP_EN.
//
//   state   | meaning
//   ST_RUN  | counting on prescaler ticks
//   ST_DONE | one-shot reached terminal; count frozen until load or arst
module counter_updown_presc_tristate
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               PRESC_W   = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                        clk,
    input  logic                                        arst,
    counter_updown_presc_tristate_if.slave              bus,
    output wire  [WIDTH-1:0]                            q
);

    cnt_state_e       state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d;
    logic             tc_d, done_d;
    logic             tick;
    logic             terminal;

    counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .arst  (arst),
        .en    (bus.en),
        .clr   (bus.load),
        .presc (bus.presc),
        .tick  (tick)
    );

    // ">=" so that a loaded value above max_val still terminates the up-count
    assign terminal = bus.up ? (cnt >= bus.max_val) : (cnt == '0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        tc_d    = 1'b0;
        done_d  = bus.done;
        if (bus.load) begin
            state_d = ST_RUN;
            cnt_d   = bus.load_val;
            done_d  = 1'b0;
        end else if (tick && state == ST_RUN) begin
            if (!terminal) begin
                cnt_d = bus.up ? cnt + 1'b1 : cnt - 1'b1;
            end else begin
                tc_d = 1'b1;
                case (cnt_mode_e'(bus.mode))
                    MODE_SAT: begin
                        cnt_d = cnt;
                    end
                    MODE_ONESHOT: begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        cnt_d = bus.up ? '0 : bus.max_val;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_RUN;
            cnt      <= RESET_VAL;
            bus.tc   <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bus.tc   <= tc_d;
            bus.done <= done_d;
        end
    end

`ifdef COUNTER_CMP_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bus.match <= 1'b0;
        end else begin
            bus.match <= (cnt_d != cnt) && (cnt_d == bus.cmp_val);
        end
    end
`endif

    assign q = bus.oe ? cnt : {WIDTH{1'bz}};

endmodule

// File: tb/tb_counter_updown_presc_tristate.sv
// Directed self-checking bench for counter_updown_presc_tristate (WIDTH=8, PRESC_W=4, RESET_VAL=0).
module tb_counter_updown_presc_tristate;

    logic       clk = 1'b0;
    logic       arst;
    wire  [7:0] q;
    int         n_cmp  = 0;
    int         n_fail = 0;

    counter_updown_presc_tristate_if #(.WIDTH(8), .PRESC_W(4)) bus ();

    counter_updown_presc_tristate #(.WIDTH(8), .PRESC_W(4), .RESET_VAL(8'd0)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus),
        .q    (q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // down/saturate with presc=2: q and tc after each of 12 cycles
    logic [7:0] sat_q  [12] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       sat_tc [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        arst         = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.mode     = 2'b00;
        bus.load     = 1'b0;
        bus.load_val = 8'd0;
        bus.max_val  = 8'd9;
        bus.presc    = 4'd0;
        bus.oe       = 1'b1;
`ifdef COUNTER_CMP_EN
        bus.cmp_val  = 8'd6;
`endif
        step();
        step();
        check("rst_q", q, 8'd0);
        check("rst_tc", bus.tc, 1'b0);
        check("rst_done", bus.done, 1'b0);
`ifdef COUNTER_CMP_EN
        check("rst_match", bus.match, 1'b0);
`endif
        arst   = 1'b0;
        bus.en = 1'b1;

        // wrap up-count 0..9,0
        for (int i = 1; i <= 9; i++) begin
            step();
            check("wrap_q", q, 8'(i));
            check("wrap_tc", bus.tc, 1'b0);
        end
        step();
        check("wrap_q_end", q, 8'd0);
        check("wrap_tc_end", bus.tc, 1'b1);
        step();
        check("wrap_q_after", q, 8'd1);
        check("wrap_tc_after", bus.tc, 1'b0);

        // async reset mid-count at 5
        repeat (4) step();
        check("pre_rst_q", q, 8'd5);
        bus.en = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        check("arst_q", q, 8'd0);
        check("arst_tc", bus.tc, 1'b0);
        check("arst_done", bus.done, 1'b0);
        arst = 1'b0;

        // down / saturate, presc=2
        bus.load     = 1'b1;
        bus.load_val = 8'd2;
        bus.up       = 1'b0;
        bus.mode     = 2'b01;
        bus.presc    = 4'd2;
        step();
        check("sat_load_q", q, 8'd2);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("sat_q", q, sat_q[i]);
            check("sat_tc", bus.tc, sat_tc[i]);
        end

        // one-shot
        bus.load     = 1'b1;
        bus.load_val = 8'd7;
        bus.max_val  = 8'd8;
        bus.mode     = 2'b10;
        bus.up       = 1'b1;
        bus.presc    = 4'd0;
        step();
        check("os_load_q", q, 8'd7);
        bus.load = 1'b0;
        step();
        check("os_q8", q, 8'd8);
        check("os_done0", bus.done, 1'b0);
        step();
        check("os_q_term", q, 8'd8);
        check("os_done1", bus.done, 1'b1);
        check("os_tc1", bus.tc, 1'b1);
        step();
        check("os_tc_once", bus.tc, 1'b0);
        bus.up   = 1'b0;
        bus.mode = 2'b00;
        step();
        check("os_frozen_q", q, 8'd8);
        check("os_frozen_done", bus.done, 1'b1);
        check("os_frozen_tc", bus.tc, 1'b0);
        bus.load     = 1'b1;
        bus.load_val = 8'd3;
        step();
        check("os_reload_q", q, 8'd3);
        check("os_reload_done", bus.done, 1'b0);
        bus.load = 1'b0;
        bus.up   = 1'b1;
        step();
        check("os_resume_q", q, 8'd4);

        // load wins over coincident tick; value above max_val
        bus.max_val  = 8'd10;
        bus.load     = 1'b1;
        bus.load_val = 8'd20;
        step();
        check("ld_tick_q", q, 8'd20);
        check("ld_tick_tc", bus.tc, 1'b0);
        bus.load = 1'b0;
        step();
        check("ld_over_q", q, 8'd0);
        check("ld_over_tc", bus.tc, 1'b1);

        // max_val=0: every up-tick terminal
        bus.max_val = 8'd0;
        step();
        check("max0_q_a", q, 8'd0);
        check("max0_tc_a", bus.tc, 1'b1);
        step();
        check("max0_q_b", q, 8'd0);
        check("max0_tc_b", bus.tc, 1'b1);

        // tri-state: count continues while released
        bus.max_val  = 8'd10;
        bus.load     = 1'b1;
        bus.load_val = 8'd1;
        step();
        check("oe_load_q", q, 8'd1);
        bus.load = 1'b0;
        bus.oe   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            assert (q === 8'hzz) else begin
                n_fail++;
                $error("FAIL oe_hiz: observed %0h expected zz", q);
            end
`ifdef COUNTER_CMP_EN
            check("cmp_match", bus.match, (i == 5) ? 1'b1 : 1'b0);
`endif
        end
        bus.en = 1'b0;
        bus.oe = 1'b1;
        #1;
        check("oe_restore_q", q, 8'd6);
        step();
        check("oe_hold_q", q, 8'd6);
`ifdef COUNTER_CMP_EN
        check("cmp_match_once", bus.match, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
